// File: rtl/coax_rx_frontend.sv
// coax_rx_frontend: synchronise and majority-filter the coax receive line, blank it around
// transmissions, provide loopback, and report carrier presence and glitch statistics.
module coax_rx_frontend #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int HOLDOFF_BITS   = 4,
  parameter int IDLE_BITS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  input  logic       tx,
  input  logic       tx_active,
  input  logic       loopback,
  input  logic       glitch_clear,
  output logic       rx,
  output logic       carrier,
  output logic [7:0] glitch_count
);
  localparam int HOLD_N = HOLDOFF_BITS * CLOCKS_PER_BIT;
  localparam int IDLE_N = IDLE_BITS * CLOCKS_PER_BIT;
  localparam int HW = HOLD_N > 1 ? $clog2(HOLD_N) : 1;
  localparam int IW = IDLE_N > 1 ? $clog2(IDLE_N) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_N - 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_N - 1);

  typedef enum logic [1:0] {LISTEN, BLANK, HOLDOFF} state_t;

  state_t state, state_n;
  logic s0, s1;
  logic [2:0] h;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic rx_n, carrier_n;
  logic [7:0] count_n;
  logic f, glitch;

  assign f = (h[2] & h[1]) | (h[2] & h[0]) | (h[1] & h[0]);
  assign glitch = (h == 3'b010) || (h == 3'b101);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      h <= '0;
      state <= LISTEN;
      hold_cnt <= '0;
      idle_cnt <= '0;
      rx <= 1'b0;
      carrier <= 1'b0;
      glitch_count <= '0;
    end else begin
      s0 <= rx_pin;
      s1 <= s0;
      h <= {h[1:0], s1};
      state <= state_n;
      hold_cnt <= hold_n;
      idle_cnt <= idle_n;
      rx <= rx_n;
      carrier <= carrier_n;
      glitch_count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    idle_n = idle_cnt;
    rx_n = rx;
    carrier_n = carrier;
    count_n = glitch_count;
    if (loopback) begin
      state_n = LISTEN;
      hold_n = '0;
      rx_n = tx;
      carrier_n = tx_active;
    end else begin
      case (state)
        LISTEN: begin
          // an edge seen on the same cycle as tx_active still loses to blanking
          if (tx_active) begin
            state_n = BLANK;
            rx_n = 1'b0;
            carrier_n = 1'b0;
            idle_n = '0;
          end else begin
            rx_n = f;
            if (f != rx) begin
              carrier_n = 1'b1;
              idle_n = IDLE_LOAD;
            end else if (idle_cnt != '0) begin
              idle_n = idle_cnt - IW'(1);
            end else begin
              carrier_n = 1'b0;
            end
          end
        end
        BLANK: begin
          rx_n = 1'b0;
          carrier_n = 1'b0;
          idle_n = '0;
          if (!tx_active) begin
            state_n = HOLDOFF;
            hold_n = HOLD_LOAD;
          end
        end
        HOLDOFF: begin
          rx_n = 1'b0;
          carrier_n = 1'b0;
          idle_n = '0;
          if (tx_active) state_n = BLANK;
          else if (hold_cnt == '0) state_n = LISTEN;
          else hold_n = hold_cnt - HW'(1);
        end
        default: state_n = LISTEN;
      endcase
      if (state == LISTEN && glitch && glitch_count != 8'hff) count_n = glitch_count + 8'd1;
    end
    if (glitch_clear) count_n = '0;
  end
endmodule

// File: tb/tb_coax_rx_frontend.sv
// tb_coax_rx_frontend: directed and randomized checks of coax_rx_frontend against a
// timestamp-based reference model of the receive conditioning rules.
module tb_coax_rx_frontend;
  localparam int HOLD = 64;
  localparam int IDLE = 128;
  localparam int NEVER = -1000000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_pin = 1'b0;
  logic tx = 1'b0;
  logic tx_active = 1'b0;
  logic loopback = 1'b0;
  logic glitch_clear = 1'b0;
  logic rx, carrier;
  logic [7:0] glitch_count;

  int checks = 0;
  int failures = 0;

  // model: recent pin samples (index 0 newest), edge timestamps of last TX-active sample
  // and last output transition, plus expected outputs
  logic [5:0] pq;
  int cyc, last_ta, last_edge, m_cnt;
  logic m_rx, m_car;

  always #5 clk = ~clk;

  coax_rx_frontend #(.CLOCKS_PER_BIT(16), .HOLDOFF_BITS(4), .IDLE_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .rx_pin(rx_pin),
    .tx(tx),
    .tx_active(tx_active),
    .loopback(loopback),
    .glitch_clear(glitch_clear),
    .rx(rx),
    .carrier(carrier),
    .glitch_count(glitch_count)
  );

  task automatic model_reset();
    pq = '0;
    cyc = 0;
    last_ta = NEVER;
    last_edge = NEVER;
    m_cnt = 0;
    m_rx = 1'b0;
    m_car = 1'b0;
  endtask

  // one clock edge: the output at this edge follows the majority of pin samples taken 3..5 edges ago,
  // blanking lasts HOLD+1 edges after the last TX-active sample, carrier lasts IDLE edges after an output change
  task automatic tick();
    logic maj, gl, listen;
    @(posedge clk);
    cyc++;
    maj = (int'(pq[2]) + int'(pq[3]) + int'(pq[4])) >= 2;
    gl = (pq[2] != pq[3]) && (pq[3] != pq[4]);
    listen = (cyc - last_ta) > HOLD + 1;
    if (glitch_clear) m_cnt = 0;
    else if (!loopback && listen && gl && m_cnt < 255) m_cnt++;
    if (loopback) begin
      m_rx = tx;
      m_car = tx_active;
      last_ta = NEVER;
    end else if (tx_active || !listen) begin
      m_rx = 1'b0;
      m_car = 1'b0;
      last_edge = NEVER;
      if (tx_active) last_ta = cyc;
    end else begin
      if (maj != m_rx) begin
        m_rx = maj;
        last_edge = cyc;
      end
      m_car = (cyc - last_edge) < IDLE;
    end
    pq = {pq[4:0], rx_pin};
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_pin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks += 3;
      if (rx !== 1'b0) begin failures++; $display("FAIL reset_rx: got %0d expected 0", rx); end
      if (carrier !== 1'b0) begin failures++; $display("FAIL reset_carrier: got %0d expected 0", carrier); end
      if (glitch_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", glitch_count); end
    end
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks += 3;
      if (rx !== (i >= 5)) begin failures++; $display("FAIL latency_rx i=%0d: got %0d expected %0d", i, rx, i >= 5); end
      if (carrier !== (i >= 5)) begin failures++; $display("FAIL latency_carrier i=%0d: got %0d expected %0d", i, carrier, i >= 5); end
      if (glitch_count !== 8'd0) begin failures++; $display("FAIL latency_count i=%0d: got %0d expected 0", i, glitch_count); end
    end
  endtask

  task automatic test_glitch();
    rx_pin = 1'b0;
    tick();
    rx_pin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (rx !== 1'b1) begin failures++; $display("FAIL glitch_rx: got %0d expected 1", rx); end
    end
    checks++;
    if (glitch_count !== 8'd1) begin failures++; $display("FAIL glitch_one: got %0d expected 1", glitch_count); end
    for (int i = 0; i < 900; i++) begin
      rx_pin = (i % 3) != 0;
      tick();
      checks += 2;
      if (rx !== 1'b1) begin failures++; $display("FAIL glitch_train_rx i=%0d: got %0d expected 1", i, rx); end
      if (glitch_count !== m_cnt[7:0]) begin failures++; $display("FAIL glitch_train_count i=%0d: got %0d expected %0d", i, glitch_count, m_cnt); end
    end
    rx_pin = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (glitch_count !== 8'd255) begin failures++; $display("FAIL glitch_saturate: got %0d expected 255", glitch_count); end
    rx_pin = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      glitch_clear = (i == 5);
      tick();
      rx_pin = 1'b1;
    end
    glitch_clear = 1'b0;
    checks++;
    if (glitch_count !== 8'd0) begin failures++; $display("FAIL glitch_clear_wins: got %0d expected 0", glitch_count); end
  endtask

  task automatic test_blanking();
    int t = 0;
    for (int i = 0; i < 40; i++) begin rx_pin = ((t++ / 16) % 2) == 0; tick(); end
    tx_active = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      rx_pin = ((t++ / 16) % 2) == 0;
      tick();
      checks += 2;
      if (rx !== 1'b0) begin failures++; $display("FAIL blank_rx i=%0d: got %0d expected 0", i, rx); end
      if (carrier !== 1'b0) begin failures++; $display("FAIL blank_carrier i=%0d: got %0d expected 0", i, carrier); end
    end
    tx_active = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      rx_pin = ((t++ / 16) % 2) == 0;
      tick();
      checks += 2;
      if (i <= HOLD + 1 && (rx !== 1'b0 || carrier !== 1'b0)) begin
        failures++; $display("FAIL holdoff_quiet i=%0d: got rx=%0d carrier=%0d expected 0 0", i, rx, carrier);
      end
      if (rx !== m_rx) begin failures++; $display("FAIL holdoff_rx i=%0d: got %0d expected %0d", i, rx, m_rx); end
    end
    tx_active = 1'b1;
    for (int i = 0; i < 10; i++) begin rx_pin = ((t++ / 16) % 2) == 0; tick(); end
    tx_active = 1'b0;
    for (int i = 0; i < 30; i++) begin rx_pin = ((t++ / 16) % 2) == 0; tick(); end
    tx_active = 1'b1;
    for (int i = 0; i < 3; i++) begin rx_pin = ((t++ / 16) % 2) == 0; tick(); end
    tx_active = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      rx_pin = ((t++ / 16) % 2) == 0;
      tick();
      checks += 2;
      if (i <= HOLD + 1 && rx !== 1'b0) begin failures++; $display("FAIL reblank_rx i=%0d: got %0d expected 0", i, rx); end
      if (carrier !== m_car) begin failures++; $display("FAIL reblank_carrier i=%0d: got %0d expected %0d", i, carrier, m_car); end
    end
  endtask

  task automatic test_carrier();
    do_reset();
    for (int t = 0; t < 24; t++) begin rx_pin = (t >= 8 && t < 16); tick(); end
    rx_pin = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      tick();
      checks += 2;
      if (carrier !== (i < 133)) begin failures++; $display("FAIL carrier_drop i=%0d: got %0d expected %0d", i, carrier, i < 133); end
      if (rx !== (i >= 5)) begin failures++; $display("FAIL carrier_rx i=%0d: got %0d expected %0d", i, rx, i >= 5); end
    end
    rx_pin = 1'b0;
    for (int j = 1; j <= 240; j++) begin
      if (j == 100) rx_pin = 1'b1;
      tick();
      checks += 2;
      if (carrier !== (j >= 5 && j < 232)) begin failures++; $display("FAIL carrier_extend j=%0d: got %0d expected %0d", j, carrier, j >= 5 && j < 232); end
      if (carrier !== m_car) begin failures++; $display("FAIL carrier_model j=%0d: got %0d expected %0d", j, carrier, m_car); end
    end
  endtask

  task automatic test_loopback();
    logic [3:0] pat = 4'b1101;
    int g0 = m_cnt;
    loopback = 1'b1;
    tx_active = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tx = pat[i % 4];
      rx_pin = 1'($urandom);
      tick();
      checks += 3;
      if (rx !== tx) begin failures++; $display("FAIL loop_rx i=%0d: got %0d expected %0d", i, rx, tx); end
      if (carrier !== 1'b1) begin failures++; $display("FAIL loop_carrier i=%0d: got %0d expected 1", i, carrier); end
      if (glitch_count !== g0[7:0]) begin failures++; $display("FAIL loop_count i=%0d: got %0d expected %0d", i, glitch_count, g0); end
    end
    loopback = 1'b0;
    tx_active = 1'b0;
    tx = 1'b0;
    do_reset();
  endtask

  task automatic test_midframe_reset();
    rx_pin = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rx_pin = 1'b0;
    tick();
    rx_pin = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (glitch_count !== 8'd1) begin failures++; $display("FAIL mid_pre_count: got %0d expected 1", glitch_count); end
    tx_active = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tx_active = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (rx !== 1'b0) begin failures++; $display("FAIL mid_rx: got %0d expected 0", rx); end
    if (carrier !== 1'b0) begin failures++; $display("FAIL mid_carrier: got %0d expected 0", carrier); end
    if (glitch_count !== 8'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", glitch_count); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (rx !== (i >= 5)) begin failures++; $display("FAIL mid_listen i=%0d: got %0d expected %0d", i, rx, i >= 5); end
    end
  endtask

  task automatic test_random();
    int run = 0;
    int ta_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin rx_pin = ~rx_pin; run = $urandom_range(1, 20); end
      run--;
      if (ta_left == 0 && $urandom_range(0, 299) == 0) ta_left = $urandom_range(1, 40);
      tx_active = ta_left > 0;
      if (ta_left > 0) ta_left--;
      glitch_clear = $urandom_range(0, 99) == 0;
      tx = 1'($urandom);
      tick();
      checks += 3;
      if (rx !== m_rx) begin failures++; $display("FAIL rand_rx cyc=%0d: got %0d expected %0d", cyc, rx, m_rx); end
      if (carrier !== m_car) begin failures++; $display("FAIL rand_carrier cyc=%0d: got %0d expected %0d", cyc, carrier, m_car); end
      if (glitch_count !== m_cnt[7:0]) begin failures++; $display("FAIL rand_count cyc=%0d: got %0d expected %0d", cyc, glitch_count, m_cnt); end
    end
    tx_active = 1'b0;
    glitch_clear = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_blanking();
    test_carrier();
    test_loopback();
    test_midframe_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
